fir_coef_ctrl: RTL and testbench
================================

# fir_coef_ctrl

Runtime coefficient controller for `fir_filter`. It accepts a new coefficient set as a serial valid/ready stream into a shadow bank and swaps it atomically into the active bank driven onto the filter's `B` inputs. It then flushes the filter delay line with zeros, so no output ever mixes old and new coefficients. It sits between the sample source, the configuration bus and the free-running `fir_filter`, and it also generates the output-valid qualifier for `y`.

## Interface
- `N`, 4, number of taps; must match the filter.
- `WIDTH_X`, 8, sample width.
- `WIDTH_B`, 8, coefficient width.
- `B_INIT`, {N{WIDTH_B'(0)}}, flattened active-bank reset value; tap i occupies bits [i*WIDTH_B +: WIDTH_B].
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  coefficient beat valid.
- `cfg_ready`  out  1  coefficient beat accepted when high together with `cfg_valid`.
- `cfg_data`  in  WIDTH_B  coefficient; beat k is tap k (B[k]).
- `cfg_last`  in  1  marks the final beat of a set.
- `x_in_valid`  in  1  upstream sample valid.
- `x_in_ready`  out  1  sample accepted (combinational from state).
- `x_in`  in  WIDTH_X  signed sample.
- `x_out`  out  WIDTH_X  sample to the filter `x`; combinational.
- `b_out`  out  N*WIDTH_B  active coefficients to the filter `B`; registered.
- `y_valid`  out  1  filter `y` is valid and computed from the current bank.
- `swap_done`  out  1  one-cycle pulse when flush completes.
- `cfg_err`  out  1  one-cycle pulse on a malformed set.

## Operation
- The state machine has four states: IDLE, LOAD, SWAP, FLUSH.
- IDLE:
  - `cfg_ready`=1 and `x_in_ready`=1.
  - An accepted beat writes shadow[0], sets cnt=1 and moves to LOAD.
  - If that beat carries `cfg_last`, the set is malformed unless N==1.
- LOAD:
  - `cfg_ready`=1 and `x_in_ready`=1.
  - An accepted beat writes shadow[cnt] and increments cnt.
  - If the beat at cnt==N-1 has `cfg_last`=1, go to SWAP.
  - If `cfg_last`=1 at cnt<N-1, or `cfg_last`=0 at cnt==N-1, pulse `cfg_err`, discard the shadow contents and go to IDLE. The active bank is unchanged.
- SWAP:
  - `cfg_ready`=0 and `x_in_ready`=0.
  - Lasts exactly one cycle: active<=shadow, cnt<=0, then go to FLUSH.
- FLUSH:
  - `cfg_ready`=0 and `x_in_ready`=0.
  - Lasts N+1 cycles, counted by cnt. On the edge where cnt==N, go to IDLE and register `swap_done`=1 for one cycle.
- `x_out`:
  - `x_in` when `x_in_valid && x_in_ready`, else 0.
  - The filter free-runs, so an upstream bubble inserts a zero sample. This is intended behaviour.
- `y_valid`:
  - Driven by a shift register of depth N+1 fed with `x_in_valid && x_in_ready`.
  - `y_valid` is the tap at depth N+1, matching filter latency (x registered, y registered).
  - Flush zeros carry valid=0.
- Widths: cnt is $clog2(N+1) bits. No arithmetic is performed on data.
- Reset values:
  - State IDLE, cnt=0, shadow all 0, active=`B_INIT`.
  - Valid pipe all 0.
  - `y_valid`, `swap_done`, `cfg_err` = 0.
  - `cfg_ready`=1 and `x_in_ready`=1 once state is IDLE.
- Reset asserted mid-LOAD, SWAP or FLUSH: the partial set is lost, active returns to `B_INIT`, and no `swap_done` or `cfg_err` pulse is emitted.

## Timing
- A cfg beat transfers on a rising edge with `cfg_valid && cfg_ready`. There is no throughput limit: one beat per cycle.
- Final beat accepted at edge E0:
  - SWAP is occupied in the cycle after E0.
  - `b_out` takes the new value after edge E0+1.
  - FLUSH covers the cycles after edges E0+1 … E0+N+1.
  - `x_in_ready` is low for exactly N+2 cycles.
  - `swap_done` is high in the cycle after edge E0+N+2, together with `x_in_ready`=1.
- First sample accepted after the flush at edge S: `y_valid`=1 in the cycle after edge S+N+1, and `y` equals B_new[0]·x with zero history.
- `cfg_valid` held during SWAP/FLUSH is stalled, not dropped. It is accepted in the first IDLE cycle.
- A sample offered during SWAP/FLUSH stalls upstream. `x_out` is 0 in those cycles.
- `cfg_err` is registered: it is high in the cycle after the offending beat's edge. The state is IDLE in that same cycle.

## Test plan
- Reset with `B_INIT`={1,2,3,4} and a continuous random x for 100 cycles -> `b_out`={1,2,3,4}. `y_valid` rises N+1 cycles after the first accepted sample, and every valid y matches a 4-tap reference.
- Load {5,-1,0,7} back-to-back with last on beat 3 -> `x_in_ready` low for 6 cycles, `b_out`={5,-1,0,7} after E0+1, one `swap_done` pulse. The first post-flush y equals 5·x0; there are no valid outputs during the swap.
- Load with `cfg_last` on beat 1 -> `cfg_err` pulse, `b_out` still {1,2,3,4}, state IDLE. A following good set loads correctly.
- Load 4 beats with no `cfg_last` -> `cfg_err` after beat 3, no swap.
- Hold `cfg_valid` high during FLUSH with beat value 9 -> `cfg_ready`=0 until `swap_done`. The beat is accepted in that cycle as tap 0 of the next set.
- Assert `rst` in the second FLUSH cycle -> `b_out`=`B_INIT`, `y_valid`=0, no `swap_done`, `x_in_ready`=1 after release.

Source files
------------

// File: rtl/fir_coef_ctrl.sv
// Loads a coefficient set into a shadow bank, swaps it into the active bank, then zero-flushes the filter.
// b_out updates one cycle after the last beat; cfg and sample inputs stall (ready low) for N+2 cycles per swap.
module fir_coef_ctrl #(
  parameter int N       = 4,
  parameter int WIDTH_X = 8,
  parameter int WIDTH_B = 8,
  parameter logic [N*WIDTH_B-1:0] B_INIT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [WIDTH_B-1:0]     cfg_data,
  input  logic                   cfg_last,
  input  logic                   x_in_valid,
  output logic                   x_in_ready,
  input  logic [WIDTH_X-1:0]     x_in,
  output logic [WIDTH_X-1:0]     x_out,
  output logic [N*WIDTH_B-1:0]   b_out,
  output logic                   y_valid,
  output logic                   swap_done,
  output logic                   cfg_err
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SWAP, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CW-1:0]        wr_idx;
  logic                 is_end;
  logic                 rdy;
  logic                 shadow_we, shadow_clr, bank_ld;
  logic                 err_nxt, done_nxt;
  logic                 x_fire;
  logic [N*WIDTH_B-1:0] shadow;
  logic [N:0]           vpipe;

  // The IDLE beat always lands in tap 0 regardless of the counter.
  assign wr_idx = (state == LOAD) ? cnt : '0;
  assign is_end = (wr_idx == CW'(N - 1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rdy        = 1'b0;
    shadow_we  = 1'b0;
    shadow_clr = 1'b0;
    bank_ld    = 1'b0;
    err_nxt    = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE, LOAD: begin
        rdy = 1'b1;
        if (cfg_valid) begin
          if (cfg_last && is_end) begin
            shadow_we = 1'b1;
            cnt_nxt   = '0;
            state_nxt = SWAP;
          end else if (cfg_last || is_end) begin
            shadow_clr = 1'b1;
            err_nxt    = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            shadow_we = 1'b1;
            cnt_nxt   = wr_idx + CW'(1);
            state_nxt = LOAD;
          end
        end
      end
      SWAP: begin
        bank_ld   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = FLUSH;
      end
      FLUSH: begin
        if (cnt == CW'(N)) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_ready  = rdy;
  assign x_in_ready = rdy;
  assign x_fire     = x_in_valid && rdy;
  // Bubbles and flush cycles feed zeros into the free-running filter.
  assign x_out      = x_fire ? x_in : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      swap_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      swap_done <= done_nxt;
      cfg_err   <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      b_out  <= B_INIT;
    end else begin
      if (shadow_clr) begin
        shadow <= '0;
      end else if (shadow_we) begin
        for (int i = 0; i < N; i++) begin
          if (wr_idx == CW'(i)) shadow[i*WIDTH_B +: WIDTH_B] <= cfg_data;
        end
      end
      if (bank_ld) b_out <= shadow;
    end
  end

  // vpipe tracks the filter delay line; the y_valid flop matches the filter's y register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe   <= '0;
      y_valid <= 1'b0;
    end else begin
      vpipe   <= {vpipe[N-1:0], x_fire};
      y_valid <= vpipe[N];
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: reset, swap timing, malformed sets, stalled beats, reset during flush.
module tb_fir_coef_ctrl;

  localparam int N = 4;
  localparam logic [31:0] BI   = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] NEW1 = {8'd7, 8'd0, 8'hFF, 8'd5};
  localparam logic [31:0] NEW2 = {8'h40, 8'h30, 8'h20, 8'h10};
  localparam logic [31:0] NEW3 = {8'h0C, 8'h0B, 8'h0A, 8'h09};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        x_in_valid = 1'b0;
  logic        x_in_ready;
  logic [7:0]  x_in = '0;
  logic [7:0]  x_out;
  logic [31:0] b_out;
  logic        y_valid;
  logic        swap_done;
  logic        cfg_err;

  int n_checks = 0;
  int n_err    = 0;

  fir_coef_ctrl #(.N(N), .WIDTH_X(8), .WIDTH_B(8), .B_INIT(BI)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .x_in_valid(x_in_valid), .x_in_ready(x_in_ready), .x_in(x_in), .x_out(x_out),
    .b_out(b_out), .y_valid(y_valid), .swap_done(swap_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #2;
    check("rst_b_out", b_out, BI);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_x_in_ready", 32'(x_in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Continuous samples: pass-through and y_valid rise latency
    x_in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      x_in = 8'($urandom);
      #1;
      check("x_passthru", 32'(x_out), 32'(x_in));
      @(posedge clk); #1;
      check("y_valid_rise", 32'(y_valid), 32'(c >= N + 1));
    end
    x_in_valid = 1'b0;
    repeat (N + 2) @(posedge clk);
    #1;
    check("drain_y_valid", 32'(y_valid), 32'd0);
    check("idle_b_out", b_out, BI);

    // Good set {5,-1,0,7}; samples offered through swap and flush
    beat(8'd5, 1'b0);
    beat(8'hFF, 1'b0);
    beat(8'd0, 1'b0);
    beat(8'd7, 1'b1);
    cfg_valid  = 1'b0;
    cfg_last   = 1'b0;
    x_in_valid = 1'b1;
    x_in       = 8'h11;
    for (int j = 0; j <= 7; j++) begin
      #1;
      check("swap_x_in_ready", 32'(x_in_ready), 32'(j >= 6));
      check("swap_x_out", 32'(x_out), (j >= 6) ? 32'h11 : 32'h0);
      check("swap_done_pulse", 32'(swap_done), 32'(j == 6));
      check("swap_b_out", b_out, (j >= 1) ? NEW1 : BI);
      check("swap_y_valid", 32'(y_valid), 32'd0);
      @(posedge clk); #1;
    end
    x_in_valid = 1'b0;
    for (int m = 9; m <= 14; m++) begin
      @(posedge clk); #1;
      check("post_flush_y_valid", 32'(y_valid), 32'(m == 12 || m == 13));
    end

    // Early cfg_last on beat 1, then cfg_last on beat 0
    beat(8'd1, 1'b0);
    check("early_last_b0_err", 32'(cfg_err), 32'd0);
    beat(8'd2, 1'b1);
    check("early_last_err", 32'(cfg_err), 32'd1);
    check("early_last_b_out", b_out, NEW1);
    check("early_last_ready", 32'(x_in_ready), 32'd1);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    @(posedge clk); #1;
    check("early_last_err_clr", 32'(cfg_err), 32'd0);
    beat(8'd3, 1'b1);
    check("first_beat_last_err", 32'(cfg_err), 32'd1);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    @(posedge clk); #1;

    // Following good set loads correctly
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b0);
    beat(8'h40, 1'b1);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    check("set2_swap_b_out", b_out, NEW1);
    @(posedge clk); #1;
    check("set2_b_out", b_out, NEW2);
    repeat (4) @(posedge clk);
    #1;
    check("set2_done_early", 32'(swap_done), 32'd0);
    @(posedge clk); #1;
    check("set2_done", 32'(swap_done), 32'd1);
    @(posedge clk); #1;
    check("set2_done_clr", 32'(swap_done), 32'd0);

    // Four beats without cfg_last
    for (int k = 0; k < 4; k++) begin
      beat(8'h55, 1'b0);
      check("no_last_err", 32'(cfg_err), 32'(k == 3));
    end
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("no_last_ready", 32'(x_in_ready), 32'd1);
      check("no_last_b_out", b_out, NEW2);
      check("no_last_swap", 32'(swap_done), 32'd0);
    end

    // Beat held through swap/flush becomes tap 0 of the next set
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b0);
    beat(8'd4, 1'b1);
    cfg_valid = 1'b1;
    cfg_data  = 8'h09;
    cfg_last  = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      check("stall_cfg_ready", 32'(cfg_ready), 32'(j == 6));
      check("stall_swap_done", 32'(swap_done), 32'(j == 6));
      @(posedge clk); #1;
    end
    cfg_data   = 8'h0A;
    x_in_valid = 1'b1;
    x_in       = 8'h22;
    @(posedge clk); #1;
    cfg_data = 8'h0B;
    @(posedge clk); #1;
    cfg_data = 8'h0C;
    cfg_last = 1'b1;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    cfg_last   = 1'b0;
    x_in_valid = 1'b0;
    @(posedge clk); #1;
    check("held_beat_b_out", b_out, NEW3);

    // Reset in the second flush cycle
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("flush_rst_b_out", b_out, BI);
    check("flush_rst_y_valid", 32'(y_valid), 32'd0);
    check("flush_rst_swap_done", 32'(swap_done), 32'd0);
    check("flush_rst_cfg_err", 32'(cfg_err), 32'd0);
    check("flush_rst_ready", 32'(x_in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("after_rst_swap_done", 32'(swap_done), 32'd0);
      check("after_rst_y_valid", 32'(y_valid), 32'd0);
      check("after_rst_ready", 32'(x_in_ready), 32'd1);
      check("after_rst_b_out", b_out, BI);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
